palette_loader: RTL and testbench

- Writer side of the NES video palette-RAM load interface.
- Accepts a user palette file (.pal, raw RGB byte triplets) streamed from the HPS ioctl download channel.
- Assembles each triplet into a 24-bit colour and issues single-cycle writes (load_color / load_color_index / load_color_data) into the 64-entry custom palette RAM in the video block.
- Tracks file progress, paces the download, flags malformed streams, and reports when a complete palette is resident.

---
 rtl/palette_loader.sv | 208 ++++++++++++++++++++
 tb/tb_palette_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
// Streams a raw RGB .pal file from the ioctl download channel into the
// 64-entry video palette RAM, pacing the HPS with dl_wait and flagging bad streams.
module palette_loader #(
    parameter int ENTRIES     = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [10:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        load_color,
    output logic [5:0]  load_color_index,
    output logic [23:0] load_color_data,
    output logic        pal_loaded,
    output logic        load_done,
    output logic        load_error,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_HOLD    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    localparam logic [6:0] LP_ENTRIES   = 7'(ENTRIES);
    localparam logic [3:0] LP_HOLD_LAST = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic        r_active_q;
    logic        r_start_pend;
    logic        r_fall_pend;
    logic [1:0]  r_lane;
    logic [6:0]  r_index;
    logic [10:0] r_expected;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic        r_skid_v;
    logic [10:0] r_skid_addr;
    logic [7:0]  r_skid_data;
    logic [3:0]  r_hold_cnt;
    logic        r_load_color;
    logic [5:0]  r_idx_out;
    logic [23:0] r_data_out;
    logic        r_pal_loaded;
    logic        r_load_done;
    logic        r_load_error;

    logic        w_rise;
    logic        w_fall;
    logic        w_byte_v;
    logic [10:0] w_byte_addr;
    logic [7:0]  w_byte_data;
    logic        w_addr_ok;
    logic        w_store;
    logic        w_last;
    logic        w_stall_wr;

    assign w_rise     = dl_active & ~r_active_q;
    assign w_fall     = ~dl_active & r_active_q;
    assign w_stall_wr = dl_wr & ((r_state == S_WRITE) | (r_state == S_HOLD));

    // A held skid byte always goes ahead of a live strobe so file order is kept.
    always_comb begin
        w_byte_v    = 1'b0;
        w_byte_addr = dl_addr;
        w_byte_data = dl_data;
        if (r_state == S_COLLECT) begin
            if (r_skid_v) begin
                w_byte_v    = 1'b1;
                w_byte_addr = r_skid_addr;
                w_byte_data = r_skid_data;
            end else begin
                w_byte_v = dl_wr;
            end
        end
    end

    assign w_addr_ok = (w_byte_addr == r_expected);
    assign w_store   = w_byte_v & w_addr_ok & (r_index < LP_ENTRIES);
    assign w_last    = w_store & (r_lane == 2'd2);

    assign dl_wait          = w_last | (r_state == S_WRITE) | (r_state == S_HOLD);
    assign load_color       = r_load_color;
    assign load_color_index = r_idx_out;
    assign load_color_data  = r_data_out;
    assign pal_loaded       = r_pal_loaded;
    assign load_done        = r_load_done;
    assign load_error       = r_load_error;
    assign dbg_state        = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_active_q   <= 1'b0;
            r_start_pend <= 1'b0;
            r_fall_pend  <= 1'b0;
            r_lane       <= 2'd0;
            r_index      <= 7'd0;
            r_expected   <= 11'd0;
            r_red        <= 8'd0;
            r_green      <= 8'd0;
            r_skid_v     <= 1'b0;
            r_skid_addr  <= 11'd0;
            r_skid_data  <= 8'd0;
            r_hold_cnt   <= 4'd0;
            r_load_color <= 1'b0;
            r_idx_out    <= 6'd0;
            r_data_out   <= 24'd0;
            r_pal_loaded <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_active_q   <= dl_active;
            r_load_color <= 1'b0;
            r_load_done  <= 1'b0;
            if ((r_state != S_IDLE) && w_rise) r_start_pend <= 1'b1;
            if ((r_state != S_IDLE) && w_fall) r_fall_pend <= 1'b1;
            if (w_stall_wr) begin
                if (r_skid_v) begin
                    r_load_error <= 1'b1;
                end else begin
                    r_skid_v    <= 1'b1;
                    r_skid_addr <= dl_addr;
                    r_skid_data <= dl_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise || r_start_pend) begin
                        r_pal_loaded <= 1'b0;
                        r_load_error <= 1'b0;
                        r_lane       <= 2'd0;
                        r_index      <= 7'd0;
                        r_expected   <= 11'd0;
                        r_skid_v     <= 1'b0;
                        r_start_pend <= 1'b0;
                        r_fall_pend  <= 1'b0;
                        r_state      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (r_skid_v) begin
                        r_skid_v    <= dl_wr;
                        r_skid_addr <= dl_addr;
                        r_skid_data <= dl_data;
                    end
                    if (w_byte_v) begin
                        if (!w_addr_ok) begin
                            r_load_error <= 1'b1;
                        end else begin
                            r_expected <= r_expected + 11'd1;
                            // The 11-bit address would alias after 2047 bytes.
                            if (r_expected == 11'h7FF) r_load_error <= 1'b1;
                        end
                        if (w_store) begin
                            case (r_lane)
                                2'd0: begin
                                    r_red  <= w_byte_data;
                                    r_lane <= 2'd1;
                                end
                                2'd1: begin
                                    r_green <= w_byte_data;
                                    r_lane  <= 2'd2;
                                end
                                default: begin
                                    r_load_color <= 1'b1;
                                    r_idx_out    <= r_index[5:0];
                                    r_data_out   <= {r_red, r_green, w_byte_data};
                                    r_state      <= S_WRITE;
                                end
                            endcase
                        end
                    end else if (!dl_active || r_fall_pend) begin
                        r_fall_pend <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end
                S_WRITE: begin
                    r_index    <= r_index + 7'd1;
                    r_lane     <= 2'd0;
                    r_hold_cnt <= LP_HOLD_LAST;
                    if ((r_index + 7'd1) == LP_ENTRIES) r_pal_loaded <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold_cnt == 4'd0) r_state <= S_COLLECT;
                    else r_hold_cnt <= r_hold_cnt - 4'd1;
                end
                S_DRAIN: begin
                    if ((r_lane != 2'd0) || (r_index < LP_ENTRIES)) r_load_error <= 1'b1;
                    r_load_done <= 1'b1;
                    r_skid_v    <= 1'b0;
                    r_fall_pend <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: streams whole and damaged .pal files and
// checks palette writes, pacing and status flags against hand-derived values.
module tb_palette_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [10:0] dl_addr = 11'd0;
    logic [7:0]  dl_data = 8'd0;
    logic        dl_wait;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic        pal_loaded;
    logic        load_done;
    logic        load_error;
    logic [2:0]  dbg_state;

    int n_pass = 0;
    int n_total = 0;

    palette_loader #(.ENTRIES(64), .WAIT_CYCLES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .dl_active        (dl_active),
        .dl_wr            (dl_wr),
        .dl_addr          (dl_addr),
        .dl_data          (dl_data),
        .dl_wait          (dl_wait),
        .load_color       (load_color),
        .load_color_index (load_color_index),
        .load_color_data  (load_color_data),
        .pal_loaded       (pal_loaded),
        .load_done        (load_done),
        .load_error       (load_error),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    // Palette RAM model and activity counters, sampled on the falling edge.
    logic [23:0] mem [64];
    int wr_cnt, done_cnt, wait_cnt, last_idx, cyc, last_wr_cyc, min_gap;

    initial cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (load_color) begin
            mem[load_color_index] = load_color_data;
            wr_cnt   = wr_cnt + 1;
            last_idx = int'(load_color_index);
            if (last_wr_cyc >= 0 && (cyc - last_wr_cyc) < min_gap) min_gap = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
        end
        if (load_done) done_cnt = done_cnt + 1;
        if (dl_wait) wait_cnt = wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        if (kind == 0) return 8'(i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [23:0] entry(input int kind, input int k);
        return {pat(kind, 3 * k), pat(kind, 3 * k + 1), pat(kind, 3 * k + 2)};
    endfunction

    task automatic clear_stats();
        wr_cnt      = 0;
        done_cnt    = 0;
        wait_cnt    = 0;
        last_idx    = -1;
        last_wr_cyc = -1;
        min_gap     = 1000;
        for (int i = 0; i < 64; i++) mem[i] = 24'hEEEEEE;
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        tick(2);
    endtask

    task automatic send(input int addr, input logic [7:0] data, input int gap);
        dl_wr   = 1'b1;
        dl_addr = 11'(addr);
        dl_data = data;
        tick(1);
        dl_wr = 1'b0;
        tick(gap - 1);
    endtask

    task automatic end_dl(input string tag);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        dl_active = 1'b0;
        while (done_cnt == d0 && k < 30) begin
            tick(1);
            k++;
        end
        tick(2);
        check({tag, "_load_done"}, done_cnt, d0 + 1);
    endtask

    task automatic check_entries(input string tag, input int kind, input int nent);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (k < nent) begin
                if (mem[k] !== entry(kind, k)) bad++;
            end else if (mem[k] !== 24'hEEEEEE) begin
                bad++;
            end
        end
        check({tag, "_entries_bad"}, bad, 0);
    endtask

    initial begin
        clear_stats();
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_load_color", load_color, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_index", load_color_index, 0);
        check("rst_data", load_color_data, 0);
        check("rst_flags", {pal_loaded, load_done, load_error}, 0);
        check("rst_state", dbg_state, 0);

        // Full 192-byte palette, one strobe every 4 cycles.
        clear_stats();
        start_dl();
        check("full_state_collect", dbg_state, 1);
        for (int i = 0; i < 192; i++) send(i, pat(0, i), 4);
        end_dl("full");
        check("full_writes", wr_cnt, 64);
        check("full_entry0", mem[0], 24'h000102);
        check("full_entry63", mem[63], 24'hBDBEBF);
        check_entries("full", 0, 64);
        check("full_pal_loaded", pal_loaded, 1);
        check("full_error", load_error, 0);
        check("full_wait_cycles", wait_cnt, 256);
        check("full_min_gap", min_gap, 12);
        tick(10);
        check("idle_pal_sticky", pal_loaded, 1);

        // Oversized 1536-byte file: only the first 192 bytes land.
        clear_stats();
        start_dl();
        check("big_pal_cleared", pal_loaded, 0);
        for (int i = 0; i < 1536; i++) send(i, pat(1, i), 4);
        end_dl("big");
        check("big_writes", wr_cnt, 64);
        check_entries("big", 1, 64);
        check("big_pal_loaded", pal_loaded, 1);
        check("big_error", load_error, 0);

        // Short 100-byte file: 33 whole triplets, trailing partial dropped.
        clear_stats();
        start_dl();
        for (int i = 0; i < 100; i++) send(i, pat(0, i), 4);
        end_dl("short");
        check("short_writes", wr_cnt, 33);
        check("short_last_idx", last_idx, 32);
        check_entries("short", 0, 33);
        check("short_error", load_error, 1);
        check("short_pal_loaded", pal_loaded, 0);

        // Address skip: byte at 7 arrives early and is dropped.
        clear_stats();
        start_dl();
        for (int i = 0; i < 6; i++) send(i, pat(0, i), 4);
        send(7, 8'hEE, 4);
        check("skip_error_now", load_error, 1);
        for (int i = 6; i < 192; i++) send(i, pat(0, i), 4);
        end_dl("skip");
        check("skip_writes", wr_cnt, 64);
        check("skip_entry2", mem[2], 24'h060708);
        check_entries("skip", 0, 64);
        check("skip_error", load_error, 1);
        check("skip_pal_loaded", pal_loaded, 1);

        // Back-to-back strobes: one byte skids, the rest overflow.
        clear_stats();
        start_dl();
        dl_wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            dl_addr = 11'(i);
            dl_data = pat(0, i);
            tick(1);
        end
        dl_wr = 1'b0;
        tick(3);
        end_dl("b2b");
        check("b2b_writes", wr_cnt, 1);
        check("b2b_entry0", mem[0], 24'h000102);
        check("b2b_wait_cycles", wait_cnt, 4);
        check("b2b_error", load_error, 1);
        check("b2b_pal_loaded", pal_loaded, 0);

        // Reset in the middle of a download, then a clean full reload.
        clear_stats();
        start_dl();
        for (int i = 0; i < 50; i++) send(i, pat(0, i), 4);
        check("mid_writes", wr_cnt, 16);
        reset = 1'b1;
        dl_active = 1'b0;
        tick(1);
        clear_stats();
        tick(1);
        reset = 1'b0;
        tick(6);
        check("mrst_writes", wr_cnt, 0);
        check("mrst_flags", {pal_loaded, load_error, dl_wait}, 0);
        check("mrst_state", dbg_state, 0);
        start_dl();
        for (int i = 0; i < 192; i++) send(i, pat(1, i), 4);
        end_dl("reload");
        check("reload_writes", wr_cnt, 64);
        check_entries("reload", 1, 64);
        check("reload_pal_loaded", pal_loaded, 1);
        check("reload_error", load_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
